// File: rtl/axi_w_slave_ctl.sv
// AXI W-channel slave controller: paces W beats against AW burst lengths and feeds the
// ingress FIFO through a 2-entry skid buffer. Optional wlast check: NOU_W_SLAVE_WLAST_CHK_EN.
`ifndef NOU_NOC_DATA_WIDTH
`define NOU_NOC_DATA_WIDTH 64
`endif

module axi_w_slave_ctl #(
    parameter int DW = `NOU_NOC_DATA_WIDTH,
    parameter int SW = DW / 8,
    parameter int LW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LW-1:0]     len,
    input  logic              len_vld,
    output logic              len_rdy,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [SW-1:0]     axi_wstrb,
    input  logic              axi_wlast,
    input  logic              axi_wvld,
    output logic              axi_wrdy,
    output logic [DW+SW:0]    wr_data,
    output logic              wr_en,
    input  logic              full,
    output logic              err_wlast,
    output logic              err_sticky,
    output logic              dbg_state
);
    localparam int EW = DW + SW + 1;

    typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   len_q, cnt;
    logic            main_vld, skid_vld, main_vld_n, skid_vld_n;
    logic [EW-1:0]   main_q, skid_q, main_n, skid_n;
    logic            wrdy_q;
    logic            accept, is_last, drain;
    logic [EW-1:0]   beat;

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
    // valid may not depend on ready, and axi_wrdy is a pure flop output.
    assign accept    = axi_wvld & wrdy_q;
    assign is_last   = (cnt == len_q);
    assign drain     = main_vld & ~full;
    assign beat      = {is_last, axi_wstrb, axi_wdata};
    assign axi_wrdy  = wrdy_q;
    assign wr_en     = drain;
    assign wr_data   = main_q;
    assign len_rdy   = (state == IDLE);
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (len_vld) state_n = DATA;
            DATA:    if (accept && is_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ready is only ever high with skid empty, so an accept never finds skid occupied
    always_comb begin
        main_vld_n = main_vld;
        main_n     = main_q;
        skid_vld_n = skid_vld;
        skid_n     = skid_q;
        if (main_vld && !drain) begin
            if (accept) begin
                skid_vld_n = 1'b1;
                skid_n     = beat;
            end
        end else if (skid_vld) begin
            main_vld_n = 1'b1;
            main_n     = skid_q;
            skid_vld_n = 1'b0;
        end else begin
            main_vld_n = accept;
            if (accept) main_n = beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt      <= '0;
            main_vld <= 1'b0;
            main_q   <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
            wrdy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            main_vld <= main_vld_n;
            main_q   <= main_n;
            skid_vld <= skid_vld_n;
            skid_q   <= skid_n;
            wrdy_q   <= (state_n == DATA) & ~skid_vld_n;
            if (state == IDLE && len_vld) begin
                len_q <= len;
                cnt   <= '0;
            end else if (state == DATA && accept && !is_last) begin
                cnt <= cnt + LW'(1);
            end
        end
    end

`ifdef NOU_W_SLAVE_WLAST_CHK_EN
    logic mismatch;
    assign mismatch = accept & (axi_wlast != is_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_wlast  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_wlast  <= mismatch;
            err_sticky <= err_sticky | mismatch;
        end
    end
`else
    logic unused_wlast;
    assign unused_wlast = axi_wlast;
    assign err_wlast    = 1'b0;
    assign err_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_w_slave_ctl.sv
// Directed + randomized bench for axi_w_slave_ctl; FIFO writes are scored against a burst-level model.
`timescale 1ns/1ps

module tb_axi_w_slave_ctl;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int LW = 8;
    localparam int EW = DW + SW + 1;
`ifdef NOU_W_SLAVE_WLAST_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] len;
    logic          len_vld, len_rdy;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          axi_wlast, axi_wvld, axi_wrdy;
    logic [EW-1:0] wr_data;
    logic          wr_en, full, err_wlast, err_sticky, dbg_state;

    always #5 clk = ~clk;

    axi_w_slave_ctl #(.DW(DW), .SW(SW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .len(len), .len_vld(len_vld), .len_rdy(len_rdy),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvld(axi_wvld), .axi_wrdy(axi_wrdy), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .err_wlast(err_wlast), .err_sticky(err_sticky), .dbg_state(dbg_state)
    );

    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            fail_cnt = 0;
    int            wr_total = 0;
    logic [EW-1:0] exp_q[$];
    int            len_model[$];
    int            beat_idx = 0;
    bit            rand_full = 1'b0;
    bit            rand_gap  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_full) full = ($urandom_range(0, 3) == 0);
    endtask

    // Model: every accepted beat becomes one FIFO entry, last set on beat number len of its burst
    task automatic push_exp(input logic [DW-1:0] d, input logic [SW-1:0] s);
        int l;
        l = (len_model.size() != 0) ? len_model[0] : 0;
        exp_q.push_back({(beat_idx == l), s, d});
        if (beat_idx == l) begin
            if (len_model.size() != 0) void'(len_model.pop_front());
            beat_idx = 0;
        end else begin
            beat_idx++;
        end
    endtask

    task automatic send_len(input int l);
        int n;
        len = LW'(l);
        len_vld = 1'b1;
        n = 0;
        while (!len_rdy && n < 200) begin
            step();
            n++;
        end
        if (!len_rdy) check("len_timeout", len_rdy, 1);
        else begin
            len_model.push_back(l);
            step();
        end
        len_vld = 1'b0;
    endtask

    task automatic send_beat(input bit wl);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int n;
        d = $urandom;
        s = SW'($urandom_range(0, 2**SW - 1));
        if (rand_gap) begin
            axi_wvld = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end
        axi_wdata = d;
        axi_wstrb = s;
        axi_wlast = wl;
        axi_wvld  = 1'b1;
        n = 0;
        while (!axi_wrdy && n < 200) begin
            step();
            n++;
        end
        if (!axi_wrdy) check("beat_timeout", axi_wrdy, 1);
        else begin
            push_exp(d, s);
            step();
        end
        axi_wvld  = 1'b0;
        axi_wlast = 1'b0;
    endtask

    // Scoreboard: every FIFO push must match the head of the expected queue
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && wr_en) begin
            wr_total++;
            if (exp_q.size() == 0) check("unexpected_write", wr_en, 0);
            else begin
                e = exp_q.pop_front();
                check("fifo_entry", wr_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, base, nb;
        bit hs;
        full = 1'b0; len = '0; len_vld = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvld = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_wrdy", axi_wrdy, 0);
        check("rst_len_rdy", len_rdy, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_wlast", err_wlast, 0);
        check("rst_err_sticky", err_sticky, 0);
        rst = 1'b0;
        step();
        check("idle_wrdy", axi_wrdy, 0);
        check("idle_wr_en", wr_en, 0);

        // len=3, four back-to-back beats
        send_len(3);
        check("t2_len_rdy_busy", len_rdy, 0);
        check("t2_wrdy_after_len", axi_wrdy, 1);
        for (int k = 0; k < 4; k++) begin
            send_beat(k == 3);
            check("t2_wr_en", wr_en, 1);
            check("t2_last", wr_data[EW-1], (k == 3));
        end
        check("t2_wrdy_drop", axi_wrdy, 0);
        step();
        check("t2_wr_en_done", wr_en, 0);
        check("t2_len_rdy_back", len_rdy, 1);

        // len=7 with full held for 10 cycles after beat 2
        send_len(7);
        for (int k = 0; k < 3; k++) send_beat(1'b0);
        full = 1'b1;
        acc = 0;
        axi_wdata = $urandom; axi_wstrb = 4'hf; axi_wlast = 1'b0; axi_wvld = 1'b1;
        repeat (10) begin
            hs = axi_wrdy;
            if (hs) push_exp(axi_wdata, axi_wstrb);
            step();
            if (hs) begin
                acc++;
                axi_wdata = $urandom;
            end
            check("t3_no_push_while_full", wr_en, 0);
        end
        axi_wvld = 1'b0;
        check("t3_wrdy_low", axi_wrdy, 0);
        check("t3_accepted_while_full", acc, 1);
        full = 1'b0;
        for (int k = 4; k < 8; k++) send_beat(k == 7);
        step();
        check("t3_drained", exp_q.size(), 0);

        // queued bursts len=0 then len=1
        base = wr_total;
        len = '0; len_vld = 1'b1;
        check("t4_len_rdy", len_rdy, 1);
        len_model.push_back(0);
        step();
        len = LW'(1);
        check("t4_len_held", len_rdy, 0);
        send_beat(1'b1);
        check("t4_bubble_wrdy", axi_wrdy, 0);
        check("t4_bubble_len_rdy", len_rdy, 1);
        len_model.push_back(1);
        step();
        len_vld = 1'b0;
        check("t4_second_wrdy", axi_wrdy, 1);
        send_beat(1'b0);
        send_beat(1'b1);
        step();
        check("t4_writes", wr_total - base, 3);

        // wlast asserted early on beat 2
        send_len(3);
        send_beat(1'b0);
        send_beat(1'b0);
        send_beat(1'b1);
        check("t5_err_pulse", err_wlast, CHK);
        check("t5_err_sticky", err_sticky, CHK);
        check("t5_beat2_not_last", wr_data[EW-1], 0);
        send_beat(1'b1);
        check("t5_err_single", err_wlast, 0);
        check("t5_sticky_held", err_sticky, CHK);
        check("t5_beat3_last", wr_data[EW-1], 1);
        step();

        // reset mid-burst with two beats buffered
        full = 1'b1;
        send_len(5);
        send_beat(1'b0);
        send_beat(1'b0);
        check("t6_wrdy_buffered", axi_wrdy, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_wrdy", axi_wrdy, 0);
        check("t6_rst_len_rdy", len_rdy, 1);
        check("t6_rst_wr_data", wr_data, 0);
        check("t6_rst_sticky", err_sticky, 0);
        exp_q.delete();
        len_model.delete();
        beat_idx = 0;
        step();
        full = 1'b0;
        rst = 1'b0;
        step();
        send_len(0);
        send_beat(1'b1);
        check("t6_post_wr_en", wr_en, 1);
        check("t6_post_last", wr_data[EW-1], 1);
        step();

        // randomized bursts with random gaps and backpressure
        rand_full = 1'b1;
        rand_gap  = 1'b1;
        for (int b = 0; b < 12; b++) begin
            nb = $urandom_range(0, 5);
            send_len(nb);
            for (int k = 0; k <= nb; k++) send_beat(k == nb);
        end
        rand_full = 1'b0;
        rand_gap  = 1'b0;
        full = 1'b0;
        repeat (6) step();
        check("final_drained", exp_q.size(), 0);
        check("final_err_wlast", err_wlast, 0);
        check("final_err_sticky", err_sticky, 0);
        check("final_len_rdy", len_rdy, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
